// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the access legality check used at request acceptance.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } lsu_state_t;

  // True when the request must be rejected: illegal size or an address
  // whose low bits do not match the natural alignment of the size.
  function automatic logic lsu_bad_access(input logic [1:0] size,
                                          input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts and extends the addressed byte/half of
// a memory word for loads, and merges sub-word store data into a memory word
// (little-endian lanes).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_byte_ofs;
  logic [4:0]  w_half_ofs;

  // Byte k lives at bits [8k+7:8k]; half h lives at bits [16h+15:16h].
  assign w_byte_ofs = {i_lane, 3'b000};
  assign w_half_ofs = {i_lane[1], 4'b0000};
  assign w_byte     = i_rdata[w_byte_ofs +: 8];
  assign w_half     = i_rdata[w_half_ofs +: 16];

  // Load result: selected lane, zero- or sign-extended to a full word.
  always_comb begin
    o_load = i_rdata;
    case (i_size)
      SZ_BYTE: o_load = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      SZ_HALF: o_load = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_load = i_rdata;
    endcase
  end

  // Store merge: overwrite only the addressed lane, keep the others.
  always_comb begin
    o_merge = i_rdata;
    case (i_size)
      SZ_BYTE: o_merge[w_byte_ofs +: 8]  = i_wdata[7:0];
      SZ_HALF: o_merge[w_half_ofs +: 16] = i_wdata[15:0];
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory port. Takes one request
// at a time, performs read / read-modify-write / write word accesses against
// a memory with one-cycle registered read latency, and returns one response.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; req_ready is high only while the FSM is IDLE, and
// req_valid is ignored in every other state. Each accepted request produces
// exactly one single-cycle resp_valid pulse (no back-pressure) with
// resp_rdata/resp_err valid in that same cycle. A reset while busy aborts
// the access with no response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic              w_accept;
  logic              w_req_bad;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merge;

  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_req_bad = lsu_bad_access(req_size, req_addr[1:0]);

  // Until CAP, r_mem_wdata holds the latched store data, so the lane merge
  // reads its low byte/half from there; CAP then replaces it with the merge.
  lsu_lane u_lane (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_lane     (r_addr[1:0]),
    .i_rdata    (mem_rdata),
    .i_wdata    (r_mem_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode: reads for loads and sub-word stores, direct write for
  // word stores, straight to the response for rejected requests.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_req_bad)                          w_next = DONE;
          else if (req_we && req_size == SZ_WORD) w_next = WR;
          else                                    w_next = RD;
        end
      end
      RD:      w_next = CAP;
      CAP:     w_next = r_we ? WR : DONE;
      WR:      w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs; nothing here depends on req_* combinationally.
  always_comb begin
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == DONE);
    mem_wen    = (r_state == WR);
    mem_addr   = '0;
    if (r_state == RD || r_state == CAP || r_state == WR)
      mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
  end

  // Request latch, load capture and store merge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_mem_wdata  <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_we         <= req_we;
      r_size       <= req_size;
      r_unsigned   <= req_unsigned;
      r_addr       <= req_addr;
      r_mem_wdata  <= req_wdata;
      r_resp_rdata <= '0;
      r_resp_err   <= w_req_bad;
    end else if (r_state == CAP) begin
      if (r_we) r_mem_wdata  <= w_merge;
      else      r_resp_rdata <= w_load;
    end
  end

  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_wdata  = r_mem_wdata;

endmodule
